cordic_nco_ctrl: RTL and testbench
==================================

# cordic_nco_ctrl

Upstream sequencer for the iterative sin/cos CORDIC core (`cordic_sin_cos`). It runs a 16-bit phase accumulator and converts each phase into a 10-bit angle, where 1024 codes span one full turn. It issues one `trig` per angle, holds the angle stable until the core returns `vld`, and captures the 13-bit cos/sin pair. Captured pairs go into a 4-deep FIFO that feeds a ready/valid output stream, turning the one-shot core into a continuous NCO sample source.

## Interface
Parameters:
- `ACC_W`, default 16: phase accumulator width. The angle is `acc[ACC_W-1 -: 10]`.
- `FIFO_DEPTH`, default 4: output FIFO depth. Must be a power of two.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `clk_vld`, in, 1: clock-enable. All state advances only on cycles where it is high.
- `soft_rst`, in, 1: synchronous clear. Has priority over `clk_vld`.
- `enable`, in, 1: run request.
- `fcw`, in, ACC_W: frequency control word, added to the accumulator per sample.
- `phase_ofs`, in, 10: static phase offset, added to the angle modulo 1024.
- `trig`, out, 1: start pulse to the CORDIC core.
- `a`, out, 10: angle to the CORDIC core.
- `vld`, in, 1: done pulse from the CORDIC core.
- `cos_in`, in, 13 signed: cosine result from the core.
- `sin_in`, in, 13 signed: sine result from the core.
- `out_valid`, out, 1: FIFO head is valid.
- `out_ready`, in, 1: downstream accepts the FIFO head.
- `out_cos`, out, 13 signed: FIFO head, cosine. Format 1.0 = 2048.
- `out_sin`, out, 13 signed: FIFO head, sine. Format 1.0 = 2048.
- `out_phase`, out, 10: angle that produced the FIFO head.
- `busy`, out, 1: high in ISSUE or WAIT.
- `timeout_err`, out, 1: sticky watchdog flag.

## Operation
- FSM states are IDLE, ISSUE and WAIT. Every transition requires `clk_vld`=1.
- IDLE → ISSUE when `enable`=1 and FIFO count < FIFO_DEPTH. Only one conversion is ever in flight, so a captured result always has a free FIFO slot.
- On entering ISSUE, register `a = acc[ACC_W-1 -: 10] + phase_ofs` (mod 1024). `trig`=1 for exactly this one clk_vld cycle. Then go to WAIT.
- `a` stays constant from ISSUE until the next ISSUE. The core uses `a` combinationally for quadrant mapping until it latches its result.
- WAIT, when `vld`=1:
  - push `{cos_in, sin_in, a}` into the FIFO;
  - set `acc <= acc + fcw`, wrapping mod 2^ACC_W;
  - go to IDLE.
- `enable` falling during ISSUE or WAIT: the current conversion completes and is pushed, then the FSM stays in IDLE.
- `fcw` and `phase_ofs` are sampled only when entering ISSUE.
- FIFO pop occurs on a cycle with `clk_vld & out_valid & out_ready`.
- Push and pop in the same cycle leave the count unchanged.
- Output data is held stable while `out_valid`=1 and `out_ready`=0.
- `soft_rst` clears the FSM to IDLE, the accumulator, the FIFO pointers, `timeout_err`, `trig` and `a`. The CORDIC core receives the same `soft_rst`, so no stale `vld` can follow.
- `rst_n` low clears all the same state asynchronously.
- Reset values:
  - `trig`=0, `a`=0, `busy`=0, `timeout_err`=0;
  - `out_valid`=0, `out_cos`=0, `out_sin`=0, `out_phase`=0.

## Timing
- Let `trig` be high in clk_vld cycle T.
  - The core's counter runs 1..14 during T+1..T+14.
  - `vld` is high in cycle T+16, with `cos_in`/`sin_in` valid in the same cycle.
- The FIFO write takes effect at the end of T+16, so `out_valid` can rise in T+17.
- Under continuous `enable` with the FIFO not full, `trig` occurs every 18 clk_vld cycles: ISSUE, WAIT×16, IDLE.
- FIFO full: the FSM holds in IDLE. Issue resumes in the first clk_vld cycle after a pop makes count < FIFO_DEPTH.
- `vld` arriving outside WAIT is ignored.
- Cycles with `clk_vld`=0 freeze all state and outputs.

## Configuration
- `CORDIC_NCO_TIMEOUT_EN` defined:
  - a 5-bit counter runs in WAIT;
  - if 31 clk_vld cycles pass without `vld`, set `timeout_err`, go to IDLE, skip the push and leave `acc` unchanged.
- Undefined:
  - no counter;
  - WAIT holds indefinitely;
  - `timeout_err` is tied to 0.

## Structure
- Package `cordic_nco_pkg` contains:
  - the FSM state enum `nco_state_t`;
  - constants `ANGLE_W=10`, `TRIG_W=13`, `CORDIC_LAT=16`, `TIMEOUT_CYC=31`;
  - the packed FIFO entry struct `nco_sample_t` (cos, sin, phase).
- Sub-module `nco_sample_fifo`: synchronous FIFO of `nco_sample_t`, gated by `clk_vld`, cleared by `soft_rst`, with a count output.

## Test plan
- `fcw`=16384, `phase_ofs`=0, `out_ready`=1, behavioural core model:
  - angles 0, 256, 512, 768 in order;
  - `out_cos` ≈ 2048, 0, −2048, 0 (±4);
  - `trig` spacing exactly 18 cycles.
- `out_ready`=0 with `enable`=1: exactly 4 conversions, then `trig` stays low. Set `out_ready`=1 for one cycle → the next `trig` fires within 2 clk_vld cycles.
- `fcw`=64 and `phase_ofs`=1020: `a` sequence is 1020, 1021, 1022, 1023, 0, 1 (wrap-around).
- `clk_vld` toggling 1-0-1-0 during a conversion: latency is 16 clk_vld-qualified cycles and all outputs freeze on the gated cycles.
- `soft_rst` in WAIT cycle T+8: FSM returns to IDLE, FIFO is empty, `a`=0, no push. A restart produces correct sample 0.
- Core model never asserts `vld`, with `CORDIC_NCO_TIMEOUT_EN` defined: `timeout_err`=1 at T+32, FSM back in IDLE, `acc` unchanged.

Source files
------------

// File: rtl/cordic_nco_ctrl_pkg.sv
// cordic_nco_pkg: shared types and constants for the CORDIC NCO sequencer.
//   nco_state_t  : sequencer FSM states (IDLE, ISSUE, WAIT)
//   nco_sample_t : one captured output sample {cos, sin, phase}
//   ANGLE_W      : angle width (1024 codes per turn)
//   TRIG_W       : width of the signed cos/sin results (1.0 = 2048)
//   CORDIC_LAT   : trig-to-vld latency of the core in clk_vld cycles
//   TIMEOUT_CYC  : WAIT cycles without vld before the watchdog fires
package cordic_nco_pkg;

  localparam int ANGLE_W     = 10;
  localparam int TRIG_W      = 13;
  localparam int CORDIC_LAT  = 16;
  localparam int TIMEOUT_CYC = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } nco_state_t;

  typedef struct packed {
    logic signed [TRIG_W-1:0]  cos;
    logic signed [TRIG_W-1:0]  sin;
    logic        [ANGLE_W-1:0] phase;
  } nco_sample_t;

endpackage

// File: rtl/cordic_nco_ctrl_if.sv
// cordic_nco_if: groups the CORDIC core handshake and the sample output stream.
//   trig/a            : start pulse and angle to the core
//   vld/cos_in/sin_in : done pulse and results from the core
//   out_valid/out_ready/out_cos/out_sin/out_phase : ready/valid sample stream
// master = sequencer side, slave = core + downstream side.
interface cordic_nco_if;
  import cordic_nco_pkg::*;

  logic                      trig;
  logic        [ANGLE_W-1:0] a;
  logic                      vld;
  logic signed [TRIG_W-1:0]  cos_in;
  logic signed [TRIG_W-1:0]  sin_in;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [TRIG_W-1:0]  out_cos;
  logic signed [TRIG_W-1:0]  out_sin;
  logic        [ANGLE_W-1:0] out_phase;

  modport master (
    output trig, a, out_valid, out_cos, out_sin, out_phase,
    input  vld, cos_in, sin_in, out_ready
  );

  modport slave (
    input  trig, a, out_valid, out_cos, out_sin, out_phase,
    output vld, cos_in, sin_in, out_ready
  );

endinterface

// File: rtl/cordic_nco_ctrl_fifo.sv
// nco_sample_fifo: small synchronous FIFO of nco_sample_t.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clk_vld        : clock enable; nothing moves while low
//   soft_rst       : synchronous pointer clear, wins over clk_vld
//   push, wr_data  : write request (dropped when full)
//   pop            : read request (ignored when empty)
//   rd_valid, rd_data : head of queue; data reads as zero while empty
//   count          : number of stored entries
module nco_sample_fifo
  import cordic_nco_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_vld,
  input  logic                     soft_rst,
  input  logic                     push,
  input  nco_sample_t              wr_data,
  input  logic                     pop,
  output logic                     rd_valid,
  output nco_sample_t              rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  nco_sample_t mem_q [DEPTH];
  logic [PW:0] wr_ptr_q;
  logic [PW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign rd_valid = (count != '0);
  assign do_pop   = clk_vld & ~soft_rst & pop & rd_valid;
  assign do_push  = clk_vld & ~soft_rst & push & (count != (PW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (soft_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
  end

  assign rd_data = rd_valid ? mem_q[rd_ptr_q[PW-1:0]] : '0;

endmodule

// File: rtl/cordic_nco_ctrl.sv
// cordic_nco_ctrl: sequencer that turns the one-shot cordic_sin_cos core into a
// continuous NCO sample stream. A phase accumulator advances by fcw per sample;
// its top 10 bits plus phase_ofs form the angle sent to the core. Results are
// queued in a FIFO feeding a ready/valid stream.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clk_vld      : clock enable for all state
//   soft_rst     : synchronous clear, priority over clk_vld
//   enable       : run request
//   fcw          : frequency control word (sampled when a conversion starts)
//   phase_ofs    : angle offset mod 1024 (sampled when a conversion starts)
//   bus          : cordic_nco_if.master (core handshake + output stream)
//   busy         : conversion in flight (ISSUE or WAIT)
//   timeout_err  : sticky watchdog flag
// Optional feature macro: CORDIC_NCO_TIMEOUT_EN enables the WAIT watchdog;
// without it WAIT holds until vld and timeout_err is constant 0.
module cordic_nco_ctrl
  import cordic_nco_pkg::*;
#(
  parameter int ACC_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_vld,
  input  logic               soft_rst,
  input  logic               enable,
  input  logic [ACC_W-1:0]   fcw,
  input  logic [ANGLE_W-1:0] phase_ofs,
  cordic_nco_if.master       bus,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  nco_state_t         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   fcw_q, fcw_d;
  logic [ANGLE_W-1:0] a_q, a_d;
  logic               fifo_push;
  logic               fifo_valid;
  nco_sample_t        wr_sample;
  nco_sample_t        head;
  logic [CNT_W-1:0]   fifo_count;

`ifdef CORDIC_NCO_TIMEOUT_EN
  logic [4:0] wait_cnt_q, wait_cnt_d;
  logic       tmo_set;
  logic       timeout_q;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fcw_d     = fcw_q;
    a_d       = a_q;
    fifo_push = 1'b0;
    wr_sample = '{cos: bus.cos_in, sin: bus.sin_in, phase: a_q};
`ifdef CORDIC_NCO_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    tmo_set    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // One conversion in flight at most, so a free slot now is a free slot at vld.
        if (enable && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
          state_d = ST_ISSUE;
          a_d     = acc_q[ACC_W-1 -: ANGLE_W] + phase_ofs;
          fcw_d   = fcw;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef CORDIC_NCO_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (bus.vld) begin
          fifo_push = 1'b1;
          acc_d     = acc_q + fcw_q;
          state_d   = ST_IDLE;
        end
`ifdef CORDIC_NCO_TIMEOUT_EN
        // The count reaching TIMEOUT_CYC-1 means TIMEOUT_CYC WAIT cycles elapsed.
        else if (wait_cnt_q == 5'(TIMEOUT_CYC - 1)) begin
          tmo_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      fcw_q   <= '0;
      a_q     <= '0;
    end else if (soft_rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      fcw_q   <= '0;
      a_q     <= '0;
    end else if (clk_vld) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fcw_q   <= fcw_d;
      a_q     <= a_d;
    end
  end

`ifdef CORDIC_NCO_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (soft_rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (clk_vld) begin
      wait_cnt_q <= wait_cnt_d;
      if (tmo_set) timeout_q <= 1'b1;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  nco_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_vld  (clk_vld),
    .soft_rst (soft_rst),
    .push     (fifo_push),
    .wr_data  (wr_sample),
    .pop      (bus.out_ready),
    .rd_valid (fifo_valid),
    .rd_data  (head),
    .count    (fifo_count)
  );

  // ISSUE lasts exactly one clk_vld cycle, so trig is simply the state decode.
  assign bus.trig      = (state_q == ST_ISSUE);
  assign bus.a         = a_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_cos   = head.cos;
  assign bus.out_sin   = head.sin;
  assign bus.out_phase = head.phase;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cordic_nco_ctrl.sv
`timescale 1ns/1ps
module tb_cordic_nco_ctrl;
  import cordic_nco_pkg::*;

  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_vld = 1'b0;
  logic             soft_rst = 1'b0;
  logic             enable = 1'b0;
  logic [ACC_W-1:0] fcw = '0;
  logic [9:0]       phase_ofs = '0;
  logic             busy;
  logic             timeout_err;

  cordic_nco_if nco_bus();

  cordic_nco_ctrl #(.ACC_W(ACC_W), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_vld     (clk_vld),
    .soft_rst    (soft_rst),
    .enable      (enable),
    .fcw         (fcw),
    .phase_ofs   (phase_ofs),
    .bus         (nco_bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Reference sin/cos in the 1.0 = 2048 format, angle in 1/1024 turns.
  function automatic int model_cos(input int ang);
    real r;
    r = 2048.0 * $cos(2.0 * 3.14159265358979 * ang / 1024.0);
    return $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
  endfunction

  function automatic int model_sin(input int ang);
    real r;
    r = 2048.0 * $sin(2.0 * 3.14159265358979 * ang / 1024.0);
    return $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
  endfunction

  // Behavioural CORDIC core: vld 16 clk_vld cycles after trig, reading a at that time.
  int   core_cnt = 0;
  logic core_mute = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || soft_rst) begin
      core_cnt       <= 0;
      nco_bus.vld    <= 1'b0;
      nco_bus.cos_in <= '0;
      nco_bus.sin_in <= '0;
    end else if (clk_vld) begin
      if (nco_bus.vld) begin
        nco_bus.vld <= 1'b0;
        core_cnt    <= 0;
      end else if (core_cnt == 0) begin
        if (nco_bus.trig) core_cnt <= 1;
      end else if (core_cnt == 15) begin
        core_cnt <= 0;
        if (!core_mute) begin
          nco_bus.vld    <= 1'b1;
          nco_bus.cos_in <= 13'(model_cos(int'(nco_bus.a)));
          nco_bus.sin_in <= 13'(model_sin(int'(nco_bus.a)));
        end
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  // Scoreboard and monitor
  typedef struct {
    int phase;
    int c;
    int s;
  } exp_t;
  exp_t exp_q[$];

  int   qc = 0;
  int   trig_cnt = 0;
  int   trig_qc[$];
  int   pop_qc = -1;
  int   first_vld_qc = -1;
  logic freeze_chk = 1'b0;
  logic prev_clk_vld = 1'b0;
  logic [49:0] snap_prev = '0;
  wire  [49:0] snap_now = {nco_bus.trig, nco_bus.a, busy, nco_bus.out_valid, nco_bus.out_cos,
                           nco_bus.out_sin, nco_bus.out_phase, timeout_err};

  always @(negedge clk) begin
    if (freeze_chk && !prev_clk_vld)
      check("freeze_on_gated_cycle", longint'(snap_now), longint'(snap_prev));
    prev_clk_vld = clk_vld;
    snap_prev    = snap_now;
    if (clk_vld) begin
      qc++;
      if (nco_bus.trig) begin
        trig_cnt++;
        trig_qc.push_back(qc);
      end
      if (nco_bus.out_valid && first_vld_qc < 0) first_vld_qc = qc;
      if (nco_bus.out_valid && nco_bus.out_ready) begin
        pop_qc = qc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sample: got phase %0d, expected no sample", nco_bus.out_phase);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("sample phase=%0d cos=%0d sin=%0d (exp phase=%0d)", nco_bus.out_phase,
                   nco_bus.out_cos, nco_bus.out_sin, e.phase);
          check("out_phase", longint'(nco_bus.out_phase), e.phase);
          check_tol("out_cos", longint'(nco_bus.out_cos), e.c, 4);
          check_tol("out_sin", longint'(nco_bus.out_sin), e.s, 4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_hand(input int ph, input int c, input int s);
    exp_t e;
    e.phase = ph; e.c = c; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic push_exp(input int ph);
    push_hand(ph, model_cos(ph), model_sin(ph));
  endtask

  task automatic do_soft_rst();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
  endtask

  task automatic wait_trigs(input int target, input int budget, input string name);
    int k = 0;
    while (trig_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check(name, trig_cnt, target);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while ((exp_q.size() != 0 || nco_bus.out_valid) && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 1 ms");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int gap;
    nco_bus.out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_trig", nco_bus.trig, 0);
    check("rst_a", nco_bus.a, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_out_valid", nco_bus.out_valid, 0);
    check("rst_out_cos", nco_bus.out_cos, 0);
    check("rst_out_sin", nco_bus.out_sin, 0);
    check("rst_out_phase", nco_bus.out_phase, 0);
    rst_n = 1'b1;
    clk_vld = 1'b1;
    tick();

    // 1: quarter-turn steps, 18-cycle trig spacing, 17-cycle trig-to-valid
    fcw = 16'd16384; phase_ofs = 10'd0;
    trig_qc.delete(); first_vld_qc = -1;
    push_hand(0, 2048, 0);
    push_hand(256, 0, 2048);
    push_hand(512, -2048, 0);
    push_hand(768, 0, -2048);
    base = trig_cnt;
    enable = 1'b1;
    wait_trigs(base + 4, 120, "t1_trig_count");
    enable = 1'b0;
    if (trig_qc.size() >= 4) begin
      for (int i = 1; i < 4; i++) check("t1_trig_spacing", trig_qc[i] - trig_qc[i-1], 18);
      check("t1_trig_to_valid", first_vld_qc - trig_qc[0], 17);
    end
    wait_drain(100, "t1_drain");

    // 2: backpressure fills the FIFO, one pop restarts issue
    do_soft_rst();
    nco_bus.out_ready = 1'b0;
    push_exp(0); push_exp(256); push_exp(512); push_exp(768);
    base = trig_cnt;
    enable = 1'b1;
    wait_trigs(base + 4, 120, "t2_trig_count");
    repeat (60) tick();
    check("t2_stalled_trig_count", trig_cnt, base + 4);
    check("t2_full_out_valid", nco_bus.out_valid, 1);
    check("t2_full_busy", busy, 0);
    push_exp(0);
    nco_bus.out_ready = 1'b1;
    tick();
    nco_bus.out_ready = 1'b0;
    wait_trigs(base + 5, 10, "t2_resume_trig");
    enable = 1'b0;
    gap = trig_qc[$] - pop_qc;
    check("t2_resume_within_2", (gap >= 1 && gap <= 2) ? 1 : 0, 1);
    nco_bus.out_ready = 1'b1;
    wait_drain(200, "t2_drain");

    // 3: phase offset wrap-around
    do_soft_rst();
    fcw = 16'd64; phase_ofs = 10'd1020;
    push_exp(1020); push_exp(1021); push_exp(1022); push_exp(1023); push_exp(0); push_exp(1);
    base = trig_cnt;
    enable = 1'b1;
    wait_trigs(base + 6, 150, "t3_trig_count");
    enable = 1'b0;
    wait_drain(100, "t3_drain");

    // 4: clk_vld toggling, outputs frozen on gated cycles
    do_soft_rst();
    fcw = 16'd16384; phase_ofs = 10'd0;
    trig_qc.delete(); first_vld_qc = -1;
    push_exp(0);
    base = trig_cnt;
    freeze_chk = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 150 && (exp_q.size() != 0 || trig_cnt == base); k++) begin
      tick();
      clk_vld = ~clk_vld;
      if (trig_cnt > base) enable = 1'b0;
    end
    clk_vld = 1'b1;
    tick();
    freeze_chk = 1'b0;
    check("t4_sample_count", exp_q.size(), 0);
    if (trig_qc.size() >= 1) check("t4_gated_trig_to_valid", first_vld_qc - trig_qc[0], 17);

    // 5: soft_rst in the middle of WAIT, then a clean restart
    do_soft_rst();
    phase_ofs = 10'd100;
    base = trig_cnt;
    enable = 1'b1;
    wait_trigs(base + 1, 20, "t5_trig");
    enable = 1'b0;
    repeat (7) tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("t5_busy_after_srst", busy, 0);
    check("t5_out_valid_after_srst", nco_bus.out_valid, 0);
    check("t5_a_after_srst", nco_bus.a, 0);
    check("t5_trig_after_srst", nco_bus.trig, 0);
    repeat (30) tick();
    check("t5_no_push", nco_bus.out_valid, 0);
    push_exp(100);
    enable = 1'b1;
    wait_trigs(base + 2, 20, "t5_restart_trig");
    enable = 1'b0;
    wait_drain(100, "t5_drain");

    // 6: core never answers
    do_soft_rst();
    phase_ofs = 10'd0;
    core_mute = 1'b1;
    base = trig_cnt;
    enable = 1'b1;
    wait_trigs(base + 1, 20, "t6_trig");
    enable = 1'b0;
`ifdef CORDIC_NCO_TIMEOUT_EN
    repeat (30) tick();
    check("t6_busy_at_T31", busy, 1);
    check("t6_no_err_at_T31", timeout_err, 0);
    tick();
    check("t6_err_at_T32", timeout_err, 1);
    check("t6_idle_at_T32", busy, 0);
    core_mute = 1'b0;
    push_exp(0);
    enable = 1'b1;
    wait_trigs(base + 2, 20, "t6_retry_trig");
    enable = 1'b0;
    wait_drain(100, "t6_drain");
    check("t6_err_sticky", timeout_err, 1);
    do_soft_rst();
    check("t6_err_cleared", timeout_err, 0);
`else
    repeat (40) tick();
    check("t6_wait_holds", busy, 1);
    check("t6_err_tied_low", timeout_err, 0);
    core_mute = 1'b0;
    do_soft_rst();
    check("t6_idle_after_srst", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
